// File: rtl/pipeline_stage_register_pkg.sv
// rtl/pipeline_stage_register_pkg.sv - shared flush type, side-effect indices and stage payload layouts
package pipeline_stage_register_pkg;

  localparam int PAYLOAD_W_DEF = 128;
  localparam int SIDE_W_DEF    = 4;

  // Pipeline-wide flush request carried on flush_i
  typedef enum logic {
    NO_FLUSH       = 1'b0,
    FLUSH_PIPELINE = 1'b1
  } flush_pipeline_sig;

  // Bit positions of the side-effect enables inside side_i / side_o
  typedef enum logic [1:0] {
    MEM_RD   = 2'd0,
    MEM_WR   = 2'd1,
    RF_WR    = 2'd2,
    FLAG_UPD = 2'd3
  } pipe_side_idx_e;

  // Per-stage payload layouts, each packed to PAYLOAD_W_DEF bits
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [63:0] rsvd;
  } if_id_payload_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
  } id_ex_payload_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [26:0] rsvd;
    logic [4:0]  rd;
  } ex_mem_payload_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] result;
    logic [31:0] load_data;
    logic [26:0] rsvd;
    logic [4:0]  rd;
  } mem_wb_payload_t;

  // Pick one named side-effect enable out of a side vector
  function automatic logic side_bit(input logic [SIDE_W_DEF-1:0] side, input pipe_side_idx_e idx);
    return side[idx];
  endfunction

endpackage

// File: rtl/pipeline_stage_register_slot.sv
// rtl/pipeline_stage_register_slot.sv - one valid+payload+side holding entry with independent valid and data writes
module pipeline_stage_register_slot
  import pipeline_stage_register_pkg::*;
#(
  parameter int PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int SIDE_W    = SIDE_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 valid_we_i,
  input  logic                 valid_in_i,
  input  logic                 data_we_i,
  input  logic [PAYLOAD_W-1:0] payload_in_i,
  input  logic [SIDE_W-1:0]    side_in_i,
  output logic                 valid_o,
  output logic [PAYLOAD_W-1:0] payload_o,
  output logic [SIDE_W-1:0]    side_o
);

  logic                 valid_d,   valid_q;
  logic [PAYLOAD_W-1:0] payload_d, payload_q;
  logic [SIDE_W-1:0]    side_d,    side_q;

  // Valid and data are written separately so a bubble or flush leaves the payload untouched
  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    side_d    = side_q;
    if (valid_we_i) valid_d = valid_in_i;
    if (data_we_i) begin
      payload_d = payload_in_i;
      side_d    = side_in_i;
    end
  end

  // Entry state, cleared asynchronously on reset
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
      side_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
      side_q    <= side_d;
    end
  end

  assign valid_o   = valid_q;
  assign payload_o = payload_q;
  assign side_o    = side_q;

endmodule

// File: rtl/pipeline_stage_register.sv
// rtl/pipeline_stage_register.sv - elastic inter-stage register with flush, bubble insertion and optional skid slot (PIPE_STAGE_SKID_EN)
module pipeline_stage_register
  import pipeline_stage_register_pkg::*;
#(
  parameter int PAYLOAD_W = PAYLOAD_W_DEF,
  parameter int SIDE_W    = SIDE_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [PAYLOAD_W-1:0] payload_i,
  input  logic [SIDE_W-1:0]    side_i,
  input  flush_pipeline_sig    flush_i,
  input  logic                 invalidate_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [PAYLOAD_W-1:0] payload_o,
  output logic [SIDE_W-1:0]    side_o,
  output logic [1:0]           occupancy_o
);

  logic                 flush;
  logic                 in_fire;
  logic                 main_valid;
  logic [PAYLOAD_W-1:0] main_payload;
  logic [SIDE_W-1:0]    main_side;
  logic                 main_valid_we, main_valid_in, main_data_we;
  logic [PAYLOAD_W-1:0] main_payload_in;
  logic [SIDE_W-1:0]    main_side_in;

  assign flush   = (flush_i == FLUSH_PIPELINE);
  assign in_fire = valid_i & ready_o;

  pipeline_stage_register_slot #(.PAYLOAD_W(PAYLOAD_W), .SIDE_W(SIDE_W)) u_main (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .valid_we_i  (main_valid_we),
    .valid_in_i  (main_valid_in),
    .data_we_i   (main_data_we),
    .payload_in_i(main_payload_in),
    .side_in_i   (main_side_in),
    .valid_o     (main_valid),
    .payload_o   (main_payload),
    .side_o      (main_side)
  );

`ifdef PIPE_STAGE_SKID_EN
  logic                 skid_valid;
  logic [PAYLOAD_W-1:0] skid_payload;
  logic [SIDE_W-1:0]    skid_side;
  logic                 skid_valid_we, skid_valid_in, skid_data_we;

  // Acceptance depends only on skid state, so ready_i never reaches ready_o combinationally
  assign ready_o = ~skid_valid & ~invalidate_i;

  pipeline_stage_register_slot #(.PAYLOAD_W(PAYLOAD_W), .SIDE_W(SIDE_W)) u_skid (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .valid_we_i  (skid_valid_we),
    .valid_in_i  (skid_valid_in),
    .data_we_i   (skid_data_we),
    .payload_in_i(payload_i),
    .side_in_i   (side_i),
    .valid_o     (skid_valid),
    .payload_o   (skid_payload),
    .side_o      (skid_side)
  );

  // Two-entry FIFO steering: flush kills both, a full skid refills main, otherwise main or skid take the new beat
  always_comb begin
    main_valid_we   = 1'b0;
    main_valid_in   = 1'b0;
    main_data_we    = 1'b0;
    main_payload_in = payload_i;
    main_side_in    = side_i;
    skid_valid_we   = 1'b0;
    skid_valid_in   = 1'b0;
    skid_data_we    = 1'b0;
    if (flush) begin
      main_valid_we = 1'b1;
      skid_valid_we = 1'b1;
    end else if (skid_valid) begin
      if (ready_i) begin
        main_valid_we   = 1'b1;
        main_valid_in   = 1'b1;
        main_data_we    = 1'b1;
        main_payload_in = skid_payload;
        main_side_in    = skid_side;
        skid_valid_we   = 1'b1;
      end
    end else if (~main_valid | ready_i) begin
      main_valid_we = 1'b1;
      main_valid_in = in_fire;
      main_data_we  = in_fire;
    end else if (in_fire) begin
      skid_valid_we = 1'b1;
      skid_valid_in = 1'b1;
      skid_data_we  = 1'b1;
    end
  end

  assign occupancy_o = {1'b0, main_valid} + {1'b0, skid_valid};
`else
  assign ready_o = (~main_valid | ready_i) & ~invalidate_i;

  // Single slot: advance whenever empty or drained; a blocked beat (invalidate) leaves a bubble
  always_comb begin
    main_valid_we   = 1'b0;
    main_valid_in   = 1'b0;
    main_data_we    = 1'b0;
    main_payload_in = payload_i;
    main_side_in    = side_i;
    if (flush) begin
      main_valid_we = 1'b1;
    end else if (~main_valid | ready_i) begin
      main_valid_we = 1'b1;
      main_valid_in = in_fire;
      main_data_we  = in_fire;
    end
  end

  assign occupancy_o = {1'b0, main_valid};
`endif

  assign valid_o   = main_valid;
  assign payload_o = main_payload;
  assign side_o    = main_side & {SIDE_W{main_valid}};

endmodule

// File: tb/tb_pipeline_stage_register.sv
// tb/tb_pipeline_stage_register.sv - scoreboard bench for pipeline_stage_register
module tb_pipeline_stage_register;
  import pipeline_stage_register_pkg::*;

`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic              clk_i = 1'b0;
  logic              reset_n_i;
  logic              valid_i;
  logic              ready_o;
  logic [127:0]      payload_i;
  logic [3:0]        side_i;
  flush_pipeline_sig flush_i;
  logic              invalidate_i;
  logic              valid_o;
  logic              ready_i;
  logic [127:0]      payload_o;
  logic [3:0]        side_o;
  logic [1:0]        occupancy_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic running = 1'b0;
  logic [131:0] exp_q[$];

  pipeline_stage_register dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .payload_i   (payload_i),
    .side_i      (side_i),
    .flush_i     (flush_i),
    .invalidate_i(invalidate_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .payload_o   (payload_o),
    .side_o      (side_o),
    .occupancy_o (occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus; the model is a FIFO of depth CAP fed by accepted beats
  task automatic step(input logic v, input logic [127:0] p, input logic [3:0] s,
                      input logic r, input logic inv, input logic fl, output logic acc);
    int  cnt;
    logic exp_ready;
    @(posedge clk_i);
    #1;
    valid_i      = v;
    payload_i    = p;
    side_i       = s;
    ready_i      = r;
    invalidate_i = inv;
    flush_i      = fl ? FLUSH_PIPELINE : NO_FLUSH;
    #2;
    cnt = exp_q.size();
    if (inv) exp_ready = 1'b0;
    else if (CAP == 2) exp_ready = (cnt < 2);
    else exp_ready = (cnt == 0) || r;
    chk("ready_o", 128'(ready_o), 128'(exp_ready));
    chk("occupancy_o", 128'(occupancy_o), 128'(cnt));
    chk("valid_o", 128'(valid_o), 128'(cnt != 0));
    acc = v & exp_ready & ~fl;
    if (fl) exp_q.delete();
    else if (v && exp_ready) exp_q.push_back({s, p});
  endtask

  // Monitor: every held beat must match the scoreboard head; pop on delivery
  initial begin
    logic [131:0] e;
    forever begin
      @(negedge clk_i);
      if (running && reset_n_i && flush_i != FLUSH_PIPELINE) begin
        if (valid_o) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 128'(valid_o), 128'(0));
          end else begin
            e = exp_q[0];
            chk("payload_o", payload_o, e[127:0]);
            chk("side_o", 128'(side_o), 128'(e[131:128]));
            if (ready_i) void'(exp_q.pop_front());
          end
        end else begin
          chk("side_o_gated", 128'(side_o), 128'(0));
        end
      end
    end
  end

  initial begin
    logic acc;
    logic [127:0] rp;
    reset_n_i    = 1'b0;
    valid_i      = 1'b0;
    payload_i    = '0;
    side_i       = '0;
    ready_i      = 1'b0;
    invalidate_i = 1'b0;
    flush_i      = NO_FLUSH;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid_o", 128'(valid_o), 128'(0));
    chk("rst_payload_o", payload_o, 128'(0));
    chk("rst_side_o", 128'(side_o), 128'(0));
    chk("rst_occupancy_o", 128'(occupancy_o), 128'(0));
    reset_n_i = 1'b1;
    running   = 1'b1;

    // Reset mid-stream with a held beat
    step(1'b1, 128'hA5, 4'b0110, 1'b0, 1'b0, 1'b0, acc);
    @(posedge clk_i);
    #2;
    chk("pre_rst_valid_o", 128'(valid_o), 128'(1));
    reset_n_i = 1'b0;
    #1;
    chk("async_rst_valid_o", 128'(valid_o), 128'(0));
    chk("async_rst_side_o", 128'(side_o), 128'(0));
    chk("async_rst_occupancy_o", 128'(occupancy_o), 128'(0));
    exp_q.delete();
    valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;

    // Streaming 1..8 back-to-back
    for (int i = 1; i <= 8; i++) step(1'b1, 128'(i), 4'(i), 1'b1, 1'b0, 1'b0, acc);
    for (int i = 0; i < 2; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);

    // Stall: 0x10 held, 0x11 offered, then release
    step(1'b1, 128'h10, 4'h1, 1'b1, 1'b0, 1'b0, acc);
    acc = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic a;
      step(~acc, 128'h11, 4'h2, 1'b0, 1'b0, 1'b0, a);
      acc = acc | a;
    end
    for (int i = 0; i < 4; i++) begin
      logic a;
      step(~acc, 128'h11, 4'h2, 1'b1, 1'b0, 1'b0, a);
      acc = acc | a;
    end
    chk("stall_0x11_accepted", 128'(acc), 128'(1));

    // Hazard bubble then acceptance
    step(1'b1, 128'h22, 4'h4, 1'b1, 1'b1, 1'b0, acc);
    chk("hazard_not_accepted", 128'(acc), 128'(0));
    step(1'b1, 128'h22, 4'h4, 1'b1, 1'b0, 1'b0, acc);
    chk("hazard_then_accepted", 128'(acc), 128'(1));
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);

    // Flush with a full stage plus an incoming beat
    for (int i = 0; i < CAP + 1; i++) step(1'b1, 128'h30 + 128'(i), 4'h8, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 128'h3F, 4'hF, 1'b1, 1'b0, 1'b1, acc);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);

    // Side gating on a bubble cycle, then on a valid beat
    step(1'b0, 128'h44, 4'hF, 1'b1, 1'b0, 1'b0, acc);
    step(1'b1, 128'h45, 4'hF, 1'b1, 1'b0, 1'b0, acc);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rp = {$urandom, $urandom, $urandom, $urandom};
      step(1'($urandom_range(0, 3) != 0), rp, 4'($urandom),
           1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 39) == 0), acc);
    end

    // Drain
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, acc);
    chk("drained", 128'(exp_q.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
